alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream issue stage for the 8-function combinational ALU (4-bit a/b, 3-bit s, 5-bit out).
//  - Buffers operation commands from a valid/ready producer and drives them one at a time
//    onto the ALU inputs.
//  - Captures the ALU result and presents it with an error flag on a valid/ready response port.
//  - Guards divide/modulo by zero, whose combinational result is undefined.
// PARAMETERS
//  DATA_W  4  operand width; result width is DATA_W+1
//  OP_W    3  opcode width (s select)
//  DEPTH   4  command FIFO entries; power of two, >=2
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  cmd_valid  in   1         command offered
//  cmd_ready  out  1         command FIFO can accept
//  cmd_op     in   OP_W      ALU opcode
//  cmd_a      in   DATA_W    operand a
//  cmd_b      in   DATA_W    operand b
//  alu_s      out  OP_W      registered select to ALU
//  alu_a      out  DATA_W    registered operand a to ALU
//  alu_b      out  DATA_W    registered operand b to ALU
//  alu_out    in   DATA_W+1  combinational ALU result
//  rsp_valid  out  1         response held
//  rsp_ready  in   1         consumer accepts response
//  rsp_data   out  DATA_W+1  captured result
//  rsp_op     out  OP_W      opcode that produced rsp_data
//  rsp_err    out  1         1 = divide/modulo by zero
// BEHAVIOUR
//  Reset:
//  - All outputs 0 except cmd_ready=1; FIFO empty; FSM=IDLE.
//  - Asserting rst_n low mid-operation discards queued and in-flight commands immediately.
//  Command FIFO:
//  - Push on cmd_valid&&cmd_ready.
//  - cmd_ready = (count<DEPTH), registered from count; no push while full, even if a pop
//    occurs in the same cycle.
//  - Pointers wrap modulo DEPTH.
//  FSM (IDLE, EXEC, RESP):
//  - IDLE: FIFO non-empty -> pop head into alu_s/a/b; ->EXEC.
//  - EXEC: one full cycle for the ALU to settle; at the next edge capture alu_out->rsp_data,
//    alu_s->rsp_op; set rsp_valid=1; ->RESP.
//  - RESP: hold rsp_* stable while rsp_valid&&!rsp_ready. On rsp_ready:
//    - FIFO non-empty -> clear rsp_valid, pop next into alu_*, ->EXEC (same edge);
//    - FIFO empty -> clear rsp_valid, ->IDLE.
//  - Simultaneous push and pop are legal in all states; a command pushed at edge t into an
//    empty FIFO in IDLE is popped at t+1.
//  Latency and throughput:
//  - Push edge t0 -> rsp_valid visible after edge t0+2 with empty FIFO and IDLE.
//  - Back-to-back throughput: one result per 2 cycles while rsp_ready=1.
//  Datapath rules:
//  - alu_s/a/b hold the last issued values when idle; never X.
//  - Divide-by-zero: op 3'b011 or 3'b100 with b==0 -> rsp_data=all ones (5'h1F), rsp_err=1,
//    alu_out ignored.
//  - Otherwise rsp_err=0 and rsp_data=alu_out unmodified; subtraction wraps mod 2^(DATA_W+1).
//  - Opcode values are all legal (3 bits fully decoded); no invalid-op path.
// STRUCTURE
//  - Shared include alu_defs.vh: opcode constants (OP_PASS..OP_GT = 3'b000..3'b111),
//    FSM state encodings, DIV0_RESULT constant.
//  - Sub-module cmd_fifo: synchronous FIFO, width OP_W+2*DATA_W, depth DEPTH, with
//    push/pop/full/empty/count.
//  - FSM and capture registers live in this module.
//  - Bench instantiates the existing ALU between alu_* and alu_out.
// TESTING
//  1. Reset: rst_n=0 -> all outputs 0, cmd_ready=1. Release, idle 5 cycles
//     -> rsp_valid stays 0.
//  2. Single op: push op=001 a=9 b=8, rsp_ready=1 -> rsp_valid 2 cycles after push,
//     rsp_data=5'h11, rsp_op=001, rsp_err=0.
//  3. Wrap/compare: push 010 a=3 b=5 then 111 a=6 b=2 -> rsp_data 5'h1E, then 5'h01,
//     in order.
//  4. Div0: push 011 a=7 b=0 and 100 a=7 b=0 -> rsp_data=5'h1F, rsp_err=1 for both.
//     Then push 011 a=7 b=2 -> 5'h03, err=0.
//  5. Full/backpressure: rsp_ready=0, push 6 commands -> cmd_ready falls after the FIFO
//     fills (4 queued + 1 issued). rsp_* stable while stalled. Release -> all 5 results in
//     push order, one per 2 cycles.
//  6. Reset mid-op: assert rst_n during EXEC with 2 queued -> outputs cleared at once; after
//     release no stale response appears.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcode values, FSM states,
// and the result substituted for a divide/modulo by zero.
package alu_cmd_sequencer_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MOD  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_GT   = 3'b111;

  localparam logic [4:0] DIV0_RESULT = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Divide and modulo are the only ops whose ALU result is undefined for b == 0.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// Command FIFO: synchronous, power-of-two depth, head visible combinationally.
// Full is decoded from the registered count, so a same-cycle pop never opens
// room for a push.
module alu_cmd_sequencer_cmd_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-function combinational ALU: queues commands, drives them
// one at a time onto the ALU, captures the result after one settle cycle and
// holds it on a valid/ready response port. Divide/modulo by zero is replaced by
// an all-ones result with the error flag set.
//
//  state   | meaning
//  IDLE    | nothing in flight; pops the FIFO head as soon as one is queued
//  EXEC    | operands on alu_*, ALU settling; result captured at the next edge
//  RESP    | response held until rsp_ready; then issues next command or idles
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [OP_W-1:0]   alu_s,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W:0]   alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W:0]   rsp_data,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_err
);

  localparam int CMD_W = OP_W + 2 * DATA_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e            r_state;
  logic [OP_W-1:0]   r_alu_s;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              r_rsp_valid;
  logic [DATA_W:0]   r_rsp_data;
  logic [OP_W-1:0]   r_rsp_op;
  logic              r_rsp_err;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [CMD_W-1:0]  w_head;
  logic              w_div0;

  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = !w_empty &&
                     ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));
  assign w_div0    = is_div_op(3'(r_alu_s)) && (r_alu_b == '0);

  alu_cmd_sequencer_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({cmd_op, cmd_a, cmd_b}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Occupancy sanity: count never exceeds depth and agrees with the empty flag.
  a_fifo_count: assert property (@(posedge clk) disable iff (!rst_n)
    (w_count <= CNT_W'(DEPTH)) && (w_empty == (w_count == '0)));

  // Issue/capture FSM; all ALU-side and response outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_alu_s     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_op    <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            {r_alu_s, r_alu_a, r_alu_b} <= w_head;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= w_div0 ? '1 : alu_out;
          r_rsp_err   <= w_div0;
          r_rsp_op    <= r_alu_s;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (!w_empty) begin
              {r_alu_s, r_alu_a, r_alu_b} <= w_head;
              r_state <= ST_EXEC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_s     = r_alu_s;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_op    = r_rsp_op;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: stands in a behavioural ALU, applies a vector
// table, hand-written stall/reset sequences and a randomized run against a
// queue-based reference model.
module tb_alu_cmd_sequencer;
  import alu_cmd_sequencer_pkg::*;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op = '0;
  logic [DATA_W-1:0] cmd_a = '0;
  logic [DATA_W-1:0] cmd_b = '0;
  logic [OP_W-1:0]   alu_s;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W:0]   alu_out;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W:0]   rsp_data;
  logic [OP_W-1:0]   rsp_op;
  logic              rsp_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err)
  );

  // Stand-in combinational ALU; returns junk (5'h0A) on divide by zero.
  always_comb begin
    alu_out = '0;
    case (alu_s)
      OP_PASS: alu_out = {1'b0, alu_a};
      OP_ADD:  alu_out = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  alu_out = {1'b0, alu_a} - {1'b0, alu_b};
      OP_DIV:  alu_out = (alu_b == 0) ? 5'h0A : {1'b0, alu_a / alu_b};
      OP_MOD:  alu_out = (alu_b == 0) ? 5'h0A : {1'b0, alu_a % alu_b};
      OP_AND:  alu_out = {1'b0, alu_a & alu_b};
      OP_OR:   alu_out = {1'b0, alu_a | alu_b};
      OP_GT:   alu_out = {4'b0, (alu_a > alu_b)};
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic [4:0] data;
    logic [2:0] op;
    logic       err;
  } rsp_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp_data;
    logic       exp_err;
  } vec_t;

  // Reference response computed with integer arithmetic from the op definitions.
  function automatic rsp_t model(input int op, input int a, input int b);
    rsp_t m;
    int   r = 0;
    logic err = 1'b0;
    case (op)
      0: r = a;
      1: r = a + b;
      2: r = a - b;
      3: if (b == 0) err = 1'b1; else r = a / b;
      4: if (b == 0) err = 1'b1; else r = a % b;
      5: r = a & b;
      6: r = a | b;
      default: r = (a > b) ? 1 : 0;
    endcase
    m.data = err ? DIV0_RESULT : 5'(r & 31);
    m.op   = 3'(op);
    m.err  = err;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"},  rsp_data, 0);
    chk({tag, "_rsp_op"},    rsp_op, 0);
    chk({tag, "_rsp_err"},   rsp_err, 0);
    chk({tag, "_alu_s"},     alu_s, 0);
    chk({tag, "_alu_a"},     alu_a, 0);
    chk({tag, "_alu_b"},     alu_b, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  // One command into an idle sequencer; checks latency and the response.
  task automatic apply_vec(input vec_t v, input int idx);
    int lat = 0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
    @(negedge clk);
    chk($sformatf("vec%0d_cmd_ready", idx), cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), lat, 2);
    chk($sformatf("vec%0d_data", idx), rsp_data, v.exp_data);
    chk($sformatf("vec%0d_op", idx), rsp_op, v.op);
    chk($sformatf("vec%0d_err", idx), rsp_err, v.exp_err);
    tick();
    chk($sformatf("vec%0d_consumed", idx), rsp_valid, 0);
  endtask

  // Backpressure: fill FIFO behind a stalled response, then drain at full rate.
  task automatic full_test();
    rsp_t exp_q[$];
    rsp_t e;
    logic [2:0] f_op [6] = '{3'd1, 3'd2, 3'd3, 3'd7, 3'd5, 3'd0};
    logic [3:0] f_a  [6] = '{4'd4, 4'd1, 4'd9, 4'd8, 4'd6, 4'd3};
    logic [3:0] f_b  [6] = '{4'd5, 4'd2, 4'd4, 4'd1, 4'd3, 4'd3};
    int last = -1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op = f_op[i]; cmd_a = f_a[i]; cmd_b = f_b[i];
      @(negedge clk);
      chk($sformatf("full_ready%0d", i), cmd_ready, (i < 5) ? 1 : 0);
      if (cmd_valid && cmd_ready) exp_q.push_back(model(f_op[i], f_a[i], f_b[i]));
      tick();
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_hold", {rsp_valid, rsp_data, rsp_op, rsp_err},
          {1'b1, exp_q[0].data, exp_q[0].op, exp_q[0].err});
      tick();
    end
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        e = exp_q.pop_front();
        chk("full_rsp", {rsp_data, rsp_op, rsp_err}, {e.data, e.op, e.err});
        if (last >= 0) chk("full_spacing", cyc - last, 2);
        last = cyc;
      end
      tick();
    end
    chk("full_drained", exp_q.size(), 0);
    chk("full_ready_after", cmd_ready, 1);
  endtask

  // Reset while EXEC with two commands queued.
  task automatic reset_midop_test();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 3'(i + 1); cmd_a = 4'(i + 5); cmd_b = 4'(i + 2);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("midop_in_exec", rsp_valid, 0);
    chk("midop_alu_a_issued", alu_a, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midop_reset");
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midop_no_stale", {rsp_valid, alu_a}, 0);
      tick();
    end
  endtask

  // Random traffic against the reference queue, with hold-stability checks.
  task automatic random_test();
    rsp_t q[$];
    rsp_t e;
    rsp_t prev;
    logic prev_stall = 1'b0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      if (cyc < 400) begin
        cmd_valid = ($urandom_range(1, 0) == 1);
        cmd_op = 3'($urandom);
        cmd_a = 4'($urandom);
        cmd_b = ($urandom_range(3, 0) == 0) ? 4'd0 : 4'($urandom);
        rsp_ready = ($urandom_range(9, 0) < 7);
      end else begin
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      if (prev_stall)
        chk("rnd_hold", {rsp_valid, rsp_data, rsp_op, rsp_err},
            {1'b1, prev.data, prev.op, prev.err});
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("rnd_unexpected_rsp", 1, 0);
        else begin
          e = q.pop_front();
          chk("rnd_rsp", {rsp_data, rsp_op, rsp_err}, {e.data, e.op, e.err});
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev.data = rsp_data; prev.op = rsp_op; prev.err = rsp_err;
      if (cmd_valid && cmd_ready) q.push_back(model(cmd_op, cmd_a, cmd_b));
      tick();
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_idle_valid", rsp_valid, 0);
  endtask

  initial begin
    vec_t vt[13];
    vt[0]  = '{3'b001, 4'd9,  4'd8,  5'h11, 1'b0};
    vt[1]  = '{3'b010, 4'd3,  4'd5,  5'h1E, 1'b0};
    vt[2]  = '{3'b111, 4'd6,  4'd2,  5'h01, 1'b0};
    vt[3]  = '{3'b011, 4'd7,  4'd0,  5'h1F, 1'b1};
    vt[4]  = '{3'b100, 4'd7,  4'd0,  5'h1F, 1'b1};
    vt[5]  = '{3'b011, 4'd7,  4'd2,  5'h03, 1'b0};
    vt[6]  = '{3'b000, 4'hC,  4'd0,  5'h0C, 1'b0};
    vt[7]  = '{3'b100, 4'hD,  4'd3,  5'h01, 1'b0};
    vt[8]  = '{3'b101, 4'hC,  4'hA,  5'h08, 1'b0};
    vt[9]  = '{3'b110, 4'h5,  4'hA,  5'h0F, 1'b0};
    vt[10] = '{3'b010, 4'd0,  4'd1,  5'h1F, 1'b0};
    vt[11] = '{3'b001, 4'hF,  4'hF,  5'h1E, 1'b0};
    vt[12] = '{3'b111, 4'd2,  4'd2,  5'h00, 1'b0};

    #3;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_no_rsp", {rsp_valid, cmd_ready}, 2'b01);
      tick();
    end

    for (int i = 0; i < 13; i++) apply_vec(vt[i], i);

    full_test();
    reset_midop_test();
    random_test();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
